// File: rtl/tournament_bp_unit.sv
// Tournament branch predictor: gshare + per-branch local history, a chooser
// table and a direct-mapped tagged BTB, with speculative global history.
module tournament_bp_unit #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned GHR_W   = 10,
  parameter int unsigned LHT_IDX = 6,
  parameter int unsigned LH_W    = 8,
  parameter int unsigned CPT_IDX = 10,
  parameter int unsigned BTB_IDX = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid_i,
  input  logic [PC_W-1:0]   pc_in_i,
  output logic              pc_sel_o,
  output logic [PC_W-1:0]   target_predict_o,
  output logic              predict_bit_o,
  output logic [GHR_W+3:0]  meta_o,
  input  logic              update_i,
  input  logic              taken_i,
  input  logic [PC_W-1:0]   pc_ex_i,
  input  logic [PC_W-1:0]   target_pc_i,
  input  logic [GHR_W+3:0]  meta_i,
  output logic              mispredict_o
);

  localparam int unsigned GPHT_N = 1 << GHR_W;
  localparam int unsigned LHT_N  = 1 << LHT_IDX;
  localparam int unsigned LPHT_N = 1 << LH_W;
  localparam int unsigned CPT_N  = 1 << CPT_IDX;
  localparam int unsigned BTB_N  = 1 << BTB_IDX;
  localparam int unsigned TAG_W  = PC_W - BTB_IDX - 2;

  logic [1:0]        r_gpht [GPHT_N];
  logic [1:0]        r_lpht [LPHT_N];
  logic [1:0]        r_cpt  [CPT_N];
  logic [LH_W-1:0]   r_lht  [LHT_N];
  logic [BTB_N-1:0]  r_btb_valid;
  logic [TAG_W-1:0]  r_btb_tag [BTB_N];
  logic [PC_W-1:0]   r_btb_tgt [BTB_N];
  logic [GHR_W-1:0]  r_spec_ghr;
  logic              r_mispredict;

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic inc);
    if (inc) return (c == 2'b11) ? c : c + 2'd1;
    else     return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Fetch-side lookup
  logic [GHR_W-1:0]   w_gidx;
  logic [LHT_IDX-1:0] w_lidx;
  logic [LH_W-1:0]    w_lhist;
  logic [CPT_IDX-1:0] w_cidx;
  logic [BTB_IDX-1:0] w_bidx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_gbit;
  logic               w_lbit;
  logic               w_final;
  logic               w_hit;

  assign w_gidx  = pc_in_i[GHR_W+1:2] ^ r_spec_ghr;
  assign w_lidx  = pc_in_i[LHT_IDX+1:2];
  assign w_lhist = r_lht[w_lidx];
  assign w_cidx  = pc_in_i[CPT_IDX+1:2];
  assign w_bidx  = pc_in_i[BTB_IDX+1:2];
  assign w_tag   = pc_in_i[PC_W-1:BTB_IDX+2];
  assign w_gbit  = r_gpht[w_gidx][1];
  assign w_lbit  = r_lpht[w_lhist][1];
  assign w_final = r_cpt[w_cidx][1] ? w_gbit : w_lbit;
  assign w_hit   = r_btb_valid[w_bidx] & (r_btb_tag[w_bidx] == w_tag);

  assign predict_bit_o    = w_final;
  assign pc_sel_o         = pred_valid_i & w_hit & w_final;
  assign target_predict_o = r_btb_tgt[w_bidx];
  assign meta_o           = {r_spec_ghr, w_gbit, w_lbit, w_final, w_hit};
  assign mispredict_o     = r_mispredict;

  // EX-side update, driven entirely by the returned metadata
  logic [GHR_W-1:0]   w_m_ghr;
  logic               w_m_g;
  logic               w_m_l;
  logic               w_m_f;
  logic               w_m_hit;
  logic [GHR_W-1:0]   w_ex_gidx;
  logic [LHT_IDX-1:0] w_ex_lidx;
  logic [LH_W-1:0]    w_ex_lhist;
  logic [CPT_IDX-1:0] w_ex_cidx;
  logic [BTB_IDX-1:0] w_ex_bidx;
  logic               w_mp;
  logic               w_resync;

  assign {w_m_ghr, w_m_g, w_m_l, w_m_f, w_m_hit} = meta_i;
  assign w_ex_gidx  = pc_ex_i[GHR_W+1:2] ^ w_m_ghr;
  assign w_ex_lidx  = pc_ex_i[LHT_IDX+1:2];
  assign w_ex_lhist = r_lht[w_ex_lidx];
  assign w_ex_cidx  = pc_ex_i[CPT_IDX+1:2];
  assign w_ex_bidx  = pc_ex_i[BTB_IDX+1:2];
  assign w_mp       = update_i & ((w_m_hit & w_m_f) != taken_i);
  assign w_resync   = update_i & (w_mp | ~w_m_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpht       <= '{default: 2'b01};
      r_lpht       <= '{default: 2'b01};
      r_cpt        <= '{default: 2'b01};
      r_lht        <= '{default: '0};
      r_btb_valid  <= '0;
      r_spec_ghr   <= '0;
      r_mispredict <= 1'b0;
    end else begin
      if (update_i) begin
        r_gpht[w_ex_gidx]  <= sat_upd(r_gpht[w_ex_gidx], taken_i);
        r_lpht[w_ex_lhist] <= sat_upd(r_lpht[w_ex_lhist], taken_i);
        r_lht[w_ex_lidx]   <= {w_ex_lhist[LH_W-2:0], taken_i};
        if (w_m_g != w_m_l)
          r_cpt[w_ex_cidx] <= sat_upd(r_cpt[w_ex_cidx], w_m_g == taken_i);
        if (taken_i)
          r_btb_valid[w_ex_bidx] <= 1'b1;
      end
      // Rebuilding from the returned history wins over a same-cycle fetch shift.
      if (w_resync)
        r_spec_ghr <= {w_m_ghr[GHR_W-2:0], taken_i};
      else if (pred_valid_i && w_hit)
        r_spec_ghr <= {r_spec_ghr[GHR_W-2:0], w_final};
      r_mispredict <= w_mp;
    end
  end

  always_ff @(posedge clk) begin
    if (update_i && taken_i) begin
      r_btb_tag[w_ex_bidx] <= pc_ex_i[PC_W-1:BTB_IDX+2];
      r_btb_tgt[w_ex_bidx] <= target_pc_i;
    end
  end

endmodule

// File: tb/tb_tournament_bp_unit.sv
// Directed bench for tournament_bp_unit with hand-computed expectations
// for the default parameter set.
module tb_tournament_bp_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid_i;
  logic [31:0] pc_in_i;
  logic        pc_sel_o;
  logic [31:0] target_predict_o;
  logic        predict_bit_o;
  logic [13:0] meta_o;
  logic        update_i;
  logic        taken_i;
  logic [31:0] pc_ex_i;
  logic [31:0] target_pc_i;
  logic [13:0] meta_i;
  logic        mispredict_o;

  int n_checks = 0;
  int n_fail   = 0;

  tournament_bp_unit #(
    .PC_W(32), .GHR_W(10), .LHT_IDX(6), .LH_W(8), .CPT_IDX(10), .BTB_IDX(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid_i(pred_valid_i), .pc_in_i(pc_in_i),
    .pc_sel_o(pc_sel_o), .target_predict_o(target_predict_o),
    .predict_bit_o(predict_bit_o), .meta_o(meta_o),
    .update_i(update_i), .taken_i(taken_i), .pc_ex_i(pc_ex_i),
    .target_pc_i(target_pc_i), .meta_i(meta_i),
    .mispredict_o(mispredict_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pred_valid_i = 1'b0;
    update_i     = 1'b0;
    taken_i      = 1'b0;
    pc_ex_i      = '0;
    target_pc_i  = '0;
    meta_i       = '0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic v);
    pc_in_i      = pc;
    pred_valid_i = v;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic [13:0] m);
    update_i    = 1'b1;
    taken_i     = t;
    pc_ex_i     = pc;
    target_pc_i = tgt;
    meta_i      = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    pc_in_i = '0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Out of reset
    lookup(32'h100, 1'b1); #1;
    chk("rst_pc_sel", pc_sel_o, 0);
    chk("rst_predict", predict_bit_o, 0);
    chk("rst_meta", meta_o, 0);
    chk("rst_mp", mispredict_o, 0);
    tick(); idle();

    // BTB fills from misses
    upd(32'h104, 1'b1, 32'h400, 14'h0); tick(); idle();
    chk("fill104_mp", mispredict_o, 1);
    upd(32'h100, 1'b1, 32'h200, 14'h0); tick(); idle();
    chk("fill100_mp", mispredict_o, 1);
    lookup(32'h100, 1'b0); #1;
    chk("fill_meta", meta_o, 14'h19);
    chk("fill_target", target_predict_o, 32'h200);
    chk("fill_predict", predict_bit_o, 0);

    // Nine more taken updates: counters saturate, local history fills with 1s
    for (int i = 0; i < 9; i++) begin
      upd(32'h100, 1'b1, 32'h200, 14'h0); tick(); idle();
    end
    chk("sat_gpht", dut.r_gpht[10'h040], 3);
    chk("sat_lpht", dut.r_lpht[8'hFF], 3);

    // Taken hit prediction at 0x100
    lookup(32'h100, 1'b1); #1;
    chk("hit_pc_sel", pc_sel_o, 1);
    chk("hit_predict", predict_bit_o, 1);
    chk("hit_target", target_predict_o, 32'h200);
    chk("hit_meta", meta_o, 14'h1F);
    tick();

    // 0x104 lookup shares the cycle with the mispredicting 0x100 update
    lookup(32'h104, 1'b1);
    upd(32'h100, 1'b0, 32'h200, 14'h1F); #1;
    chk("mp_one_cycle", mispredict_o, 0);
    chk("l104_meta", meta_o, 14'h37);
    chk("l104_pc_sel", pc_sel_o, 1);
    chk("l104_target", target_predict_o, 32'h400);
    tick(); idle();
    chk("rec_mp", mispredict_o, 1);
    lookup(32'h100, 1'b0); #1;
    chk("rec_ghr_meta", meta_o, 14'h21);
    chk("rec_gpht_dec", dut.r_gpht[10'h041], 1);
    chk("rec_lpht_dec", dut.r_lpht[8'hFF], 2);

    // Read-during-write on gidx 0x42
    lookup(32'h100, 1'b1);
    upd(32'h100, 1'b1, 32'h200, 14'h21); #1;
    chk("rdw_old", meta_o, 14'h21);
    tick(); idle();
    lookup(32'h11C, 1'b1); #1;
    chk("rdw_new_meta", meta_o, 14'h5E);
    chk("rdw_predict", predict_bit_o, 1);
    chk("rdw_miss_pc_sel", pc_sel_o, 0);
    chk("rdw_gpht", dut.r_gpht[10'h042], 2);
    chk("rdw_mp", mispredict_o, 1);

    // Mid-run asynchronous reset
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mp", mispredict_o, 0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    lookup(32'h100, 1'b1); #1;
    chk("rst2_pc_sel", pc_sel_o, 0);
    chk("rst2_predict", predict_bit_o, 0);
    chk("rst2_meta", meta_o, 0);
    chk("rst2_gpht", dut.r_gpht[10'h040], 1);
    tick(); idle();

    // Chooser training: local correct, gshare wrong on every update
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) upd(32'h300, 1'b1, 32'h340, 14'h006);
      else            upd(32'h300, 1'b0, 32'h340, 14'h008);
      tick(); idle();
    end
    chk("ch_mp_nt", mispredict_o, 0);
    chk("ch_cpt", dut.r_cpt[10'h0C0], 0);
    chk("ch_lpht_aa", dut.r_lpht[8'hAA], 3);
    chk("ch_lpht_55", dut.r_lpht[8'h55], 0);
    chk("ch_gpht", dut.r_gpht[10'h0C0], 1);
    lookup(32'h300, 1'b1); #1;
    chk("ch_predict", predict_bit_o, 1);
    chk("ch_meta", meta_o, 14'h007);
    chk("ch_pc_sel", pc_sel_o, 1);
    chk("ch_target", target_predict_o, 32'h340);
    tick(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
